// File: rtl/seg_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_display_arbiter : round-robin owner of the 7-seg driver, fade handover |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module seg_display_arbiter #(
  parameter int STEP_CYCLES = 1048576,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] req_hexx,
  input  logic [15:0] req_points,
  input  logic [3:0]  target_lum,
  output logic [3:0]  grant,
  output logic        disp_en,
  output logic [3:0]  disp_luminance,
  output logic [15:0] disp_hexx,
  output logic [3:0]  disp_points
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} state_t;

  state_t        state;
  logic [1:0]    last_owner;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          found;
  logic [SW-1:0] step_cnt;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          owner_req;
  logic          others_req;

  assign tick       = (step_cnt == SW'(STEP_CYCLES - 1));
  assign owner_req  = req[last_owner];
  assign others_req = |(req & ~grant);

  // Scan starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick  = last_owner;
    found = 1'b0;
    cand  = last_owner;
    for (int i = 1; i <= 4; i++) begin
      cand = last_owner + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_owner     <= 2'd3;
      step_cnt       <= '0;
      hold_cnt       <= '0;
      grant          <= 4'b0000;
      disp_en        <= 1'b0;
      disp_luminance <= 4'd0;
      disp_hexx      <= 16'h0000;
      disp_points    <= 4'h0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;

      if (state != IDLE && owner_req) begin
        disp_hexx   <= req_hexx[{last_owner, 4'b0000} +: 16];
        disp_points <= req_points[{last_owner, 2'b00} +: 4];
      end

      case (state)
        IDLE: begin
          if (|req) begin
            grant          <= 4'b0001 << pick;
            last_owner     <= pick;
            disp_en        <= 1'b1;
            disp_luminance <= 4'd0;
            step_cnt       <= '0;
            state          <= FADE_IN;
          end
        end
        FADE_IN: begin
          if (!owner_req) begin
            step_cnt <= '0;
            state    <= FADE_OUT;
          end else if (disp_luminance >= target_lum) begin
            step_cnt <= '0;
            hold_cnt <= '0;
            state    <= SHOW;
          end else if (tick) begin
            disp_luminance <= disp_luminance + 4'd1;
          end
        end
        SHOW: begin
          disp_luminance <= target_lum;
          if (hold_cnt != HW'(HOLD_CYCLES))
            hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req || (hold_cnt == HW'(HOLD_CYCLES) && others_req)) begin
            step_cnt <= '0;
            state    <= FADE_OUT;
          end
        end
        FADE_OUT: begin
          // Release only after a full step spent at zero brightness.
          if (tick) begin
            if (disp_luminance == 4'd0) begin
              grant    <= 4'b0000;
              disp_en  <= 1'b0;
              step_cnt <= '0;
              state    <= IDLE;
            end else begin
              disp_luminance <= disp_luminance - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for seg_display_arbiter: grant-order scoreboard plus timed fade checks.
module tb_seg_display_arbiter;

  localparam int STEP = 4;
  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_hexx;
  logic [15:0] req_points;
  logic [3:0]  target_lum;
  logic [3:0]  grant;
  logic        disp_en;
  logic [3:0]  disp_luminance;
  logic [15:0] disp_hexx;
  logic [3:0]  disp_points;

  seg_display_arbiter #(.STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_hexx       (req_hexx),
    .req_points     (req_points),
    .target_lum     (target_lum),
    .grant          (grant),
    .disp_en        (disp_en),
    .disp_luminance (disp_luminance),
    .disp_hexx      (disp_hexx),
    .disp_points    (disp_points)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_grant_q[$];
  logic [3:0] prev_grant = 4'b0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every new non-zero grant must match the next expected owner.
  always @(negedge clk) begin
    if (grant !== prev_grant && grant != 4'b0000) begin
      if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(grant), 64'd0);
      else check("grant_seq", 64'(grant), 64'(exp_grant_q.pop_front()));
    end
    prev_grant = grant;
  end

  task automatic wait_lum(input logic [3:0] v, input int budget, input string tag);
    int n = 0;
    while (disp_luminance !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(disp_luminance), 64'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int c1, c2, n;

  initial begin
    rst_n = 1'b0; req = 4'b0; req_hexx = 64'h0; req_points = 16'h0; target_lum = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_en", 64'(disp_en), 64'd0);
    check("rst_lum", 64'(disp_luminance), 64'd0);
    check("rst_hexx", 64'(disp_hexx), 64'd0);
    check("rst_points", 64'(disp_points), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_grant", 64'(grant), 64'd0);

    // Single requester fades in to target 3.
    req_hexx = 64'h0000_0000_5678_1234; req_points = 16'h00A5;
    target_lum = 4'd3; req = 4'b0001; exp_grant_q.push_back(4'b0001);
    @(negedge clk); c1 = cyc;
    check("s1_grant", 64'(grant), 64'h1);
    check("s1_lum0", 64'(disp_luminance), 64'd0);
    check("s1_en", 64'(disp_en), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) @(negedge clk);
      check("s1_lum_hold", 64'(disp_luminance), 64'(k - 1));
      @(negedge clk);
      check("s1_lum_step", 64'(disp_luminance), 64'(k));
    end
    @(negedge clk);
    check("s1_hexx", 64'(disp_hexx), 64'h1234);
    check("s1_points", 64'(disp_points), 64'h5);
    @(negedge clk);
    target_lum = 4'd9;
    @(negedge clk);
    check("s5_track_9", 64'(disp_luminance), 64'd9);
    target_lum = 4'd3; req = 4'b0011; exp_grant_q.push_back(4'b0010);
    @(negedge clk);
    check("s5_track_3", 64'(disp_luminance), 64'd3);

    // Hold expires, then fade 3..0, one idle cycle, requester 1 takes over.
    wait_lum(4'd2, 60, "s2_fade_start");
    check("s2_hold_time", 64'(cyc - c1), 64'd38);
    check("s2_owner_kept", 64'(grant), 64'h1);
    wait_lum(4'd1, 10, "s2_lum1");
    check("s2_lum1_time", 64'(cyc - c1), 64'd42);
    wait_lum(4'd0, 10, "s2_lum0");
    check("s2_lum0_time", 64'(cyc - c1), 64'd46);
    repeat (3) @(negedge clk);
    check("s2_last_owned", 64'(grant), 64'h1);
    @(negedge clk);
    check("s2_idle_grant", 64'(grant), 64'h0);
    check("s2_idle_en", 64'(disp_en), 64'd0);
    @(negedge clk); c2 = cyc;
    check("s2_new_grant", 64'(grant), 64'h2);

    // Owner drops its request during fade-in at luminance 1.
    wait_lum(4'd1, 10, "s4_lum1");
    check("s4_lum1_time", 64'(cyc - c2), 64'd4);
    check("s4_hexx_r1", 64'(disp_hexx), 64'h5678);
    check("s4_points_r1", 64'(disp_points), 64'hA);
    req = 4'b0000; req_hexx = 64'h0000_0000_BEEF_1234;
    wait_lum(4'd0, 12, "s4_lum0");
    check("s4_lum0_time", 64'(cyc - c2), 64'd9);
    repeat (4) @(negedge clk);
    check("s4_idle_grant", 64'(grant), 64'h0);
    check("s4_idle_en", 64'(disp_en), 64'd0);
    check("s4_hexx_held", 64'(disp_hexx), 64'h5678);
    repeat (5) @(negedge clk);
    check("s4_stays_idle", 64'(grant), 64'h0);

    // All four request from reset: strict rotation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_hexx = 64'h4444_3333_2222_1111;
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    req = 4'b1111;
    n = 0;
    while (exp_grant_q.size() != 0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("s3_drained", 64'(exp_grant_q.size()), 64'd0);

    // target_lum=0 goes straight to SHOW.
    req = 4'b0000; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; target_lum = 4'd0; req = 4'b0001; exp_grant_q.push_back(4'b0001);
    @(negedge clk);
    check("s5_grant", 64'(grant), 64'h1);
    @(negedge clk);
    check("s5_lum_zero", 64'(disp_luminance), 64'd0);
    target_lum = 4'd5;
    @(negedge clk);
    check("s5_show_now", 64'(disp_luminance), 64'd5);

    // Asynchronous reset in the middle of a fade-out.
    req = 4'b0000;
    wait_lum(4'd3, 20, "s6_mid_fade");
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_grant", 64'(grant), 64'h0);
    check("s6_async_en", 64'(disp_en), 64'd0);
    check("s6_async_lum", 64'(disp_luminance), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0101; exp_grant_q.push_back(4'b0001);
    @(negedge clk);
    check("s6_rr_first", 64'(grant), 64'h1);
    repeat (2) @(negedge clk);
    check("final_queue", 64'(exp_grant_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
